// File: rtl/handshake_constant_seq_if.sv
// Handshake bundle for handshake_constant_seq.
//
// Groups the control-token channel, the restart request and the registered output channel.
//   master : the side that offers tokens, requests restarts and consumes words (e.g. a bench).
//   slave  : the sequencer itself; it drives ctrl_ready, outs, outs_valid, outs_last and idx.
//
// Parameters
//   DATA_WIDTH : width of each output word.
//   IW         : index width, max(1, clog2(DEPTH)) of the attached sequencer.
interface handshake_constant_seq_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IW         = 2
);

  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic                  seq_restart;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;
  logic                  outs_last;
  logic [IW-1:0]         idx;

  modport master (
    output ctrl_valid,
    output seq_restart,
    output outs_ready,
    input  ctrl_ready,
    input  outs,
    input  outs_valid,
    input  outs_last,
    input  idx
  );

  modport slave (
    input  ctrl_valid,
    input  seq_restart,
    input  outs_ready,
    output ctrl_ready,
    output outs,
    output outs_valid,
    output outs_last,
    output idx
  );

endinterface

// File: rtl/handshake_constant_seq.sv
// Handshake-driven constant sequencer.
//
// Each accepted control token loads the next word of a constant table into a single registered
// output slot. The table index advances per token and either wraps or saturates at the last
// entry; seq_restart returns it to entry 0 without touching a word already held in the slot.
//
// Ports
//   clk : sole clock, rising edge.
//   rst : asynchronous active-low reset.
//   bus : slave side of handshake_constant_seq_if
//         ctrl_valid/ctrl_ready : control token handshake (ctrl_ready = !outs_valid | outs_ready)
//         seq_restart           : synchronous index restart
//         outs/outs_valid/outs_ready/outs_last : registered word channel, last = entry DEPTH-1
//         idx                   : index of the next entry to be emitted
//
// Parameters
//   DATA_WIDTH : word width.
//   DEPTH      : table entries, 1..256.
//   VALUES     : packed table, entry k at [k*DATA_WIDTH +: DATA_WIDTH].
//   WRAP       : 1 = index wraps DEPTH-1 -> 0, 0 = index saturates at DEPTH-1.
module handshake_constant_seq #(
  parameter int unsigned                  DATA_WIDTH = 32,
  parameter int unsigned                  DEPTH      = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0]  VALUES     = '0,
  parameter bit                           WRAP       = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  handshake_constant_seq_if.slave bus
);

  localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] outs_q, outs_d;
  logic                  outs_valid_q, outs_valid_d;
  logic                  outs_last_q, outs_last_d;
  logic [IW-1:0]         idx_q, idx_d;

  logic                  ctrl_ready;
  logic                  accept;
  logic                  emit;
  logic [DATA_WIDTH-1:0] entry_word;

  // The only combinational input-to-output path: outs_ready -> ctrl_ready.
  assign ctrl_ready = ~outs_valid_q | bus.outs_ready;
  assign accept     = bus.ctrl_valid & ctrl_ready;
  assign emit       = outs_valid_q & bus.outs_ready;

  // Table lookup by current index; out-of-range indices cannot occur but decode to zero.
  always_comb begin
    entry_word = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (idx_q == IW'(k)) begin
        entry_word = VALUES[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output slot: accept reloads (covering emit+accept with no bubble), emit alone drains.
  always_comb begin
    outs_d       = outs_q;
    outs_valid_d = outs_valid_q;
    outs_last_d  = outs_last_q;
    if (accept) begin
      outs_d       = entry_word;
      outs_last_d  = (idx_q == LastIdx);
      outs_valid_d = 1'b1;
    end else if (emit) begin
      outs_valid_d = 1'b0;
    end
  end

  // Index: restart wins over advance; the accepted token already used the pre-restart index.
  always_comb begin
    idx_d = idx_q;
    if (bus.seq_restart) begin
      idx_d = '0;
    end else if (accept) begin
      if (idx_q < LastIdx) begin
        idx_d = idx_q + IW'(1);
      end else if (WRAP) begin
        idx_d = '0;
      end else begin
        idx_d = LastIdx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outs_q       <= '0;
      outs_valid_q <= 1'b0;
      outs_last_q  <= 1'b0;
      idx_q        <= '0;
    end else begin
      outs_q       <= outs_d;
      outs_valid_q <= outs_valid_d;
      outs_last_q  <= outs_last_d;
      idx_q        <= idx_d;
    end
  end

  assign bus.ctrl_ready = ctrl_ready;
  assign bus.outs       = outs_q;
  assign bus.outs_valid = outs_valid_q;
  assign bus.outs_last  = outs_last_q;
  assign bus.idx        = idx_q;

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Directed bench for handshake_constant_seq: a wrapping and a saturating 3-entry instance plus a
// single-entry instance, all sharing clock and reset.
module tb_handshake_constant_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  localparam logic [23:0] Vals3 = {8'h33, 8'h22, 8'h11};

  handshake_constant_seq_if #(.DATA_WIDTH(8), .IW(2)) bus_a ();
  handshake_constant_seq_if #(.DATA_WIDTH(8), .IW(2)) bus_b ();
  handshake_constant_seq_if #(.DATA_WIDTH(8), .IW(1)) bus_c ();

  handshake_constant_seq #(
    .DATA_WIDTH(8), .DEPTH(3), .VALUES(Vals3), .WRAP(1'b1)
  ) dut_wrap (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );

  handshake_constant_seq #(
    .DATA_WIDTH(8), .DEPTH(3), .VALUES(Vals3), .WRAP(1'b0)
  ) dut_sat (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  handshake_constant_seq #(
    .DATA_WIDTH(8), .DEPTH(1), .VALUES(8'hA5), .WRAP(1'b1)
  ) dut_one (
    .clk(clk), .rst(rst), .bus(bus_c.slave)
  );

  task automatic idle_inputs();
    bus_a.ctrl_valid = 0; bus_a.outs_ready = 0; bus_a.seq_restart = 0;
    bus_b.ctrl_valid = 0; bus_b.outs_ready = 0; bus_b.seq_restart = 0;
    bus_c.ctrl_valid = 0; bus_c.outs_ready = 0; bus_c.seq_restart = 0;
  endtask

  // Reset pulse placed between edges; the following edge is the first with rst=1.
  task automatic pulse_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1;
    checks++; if (bus_a.outs_valid !== 1'b0) begin
      $display("FAIL reset_valid: got %b want 0", bus_a.outs_valid); errors++; end
    checks++; if (bus_a.outs !== 8'h00) begin
      $display("FAIL reset_outs: got %h want 00", bus_a.outs); errors++; end
    checks++; if (bus_a.outs_last !== 1'b0) begin
      $display("FAIL reset_last: got %b want 0", bus_a.outs_last); errors++; end
    checks++; if (bus_a.idx !== 2'd0) begin
      $display("FAIL reset_idx: got %0d want 0", bus_a.idx); errors++; end
    checks++; if (bus_a.ctrl_ready !== 1'b1) begin
      $display("FAIL reset_ready: got %b want 1", bus_a.ctrl_ready); errors++; end
    checks++; if (bus_c.outs_last !== 1'b0) begin
      $display("FAIL reset_last_d1: got %b want 0", bus_c.outs_last); errors++; end
    rst = 1'b1;
  endtask

  task automatic test_wrap_stream();
    logic [7:0] ew [5] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22};
    logic       el [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    pulse_reset();
    bus_a.ctrl_valid = 1; bus_a.outs_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus_a.outs_valid !== 1'b1 || bus_a.outs !== ew[i]) begin
        $display("FAIL wrap_word%0d: got v=%b %h want v=1 %h", i, bus_a.outs_valid, bus_a.outs,
                 ew[i]); errors++; end
      checks++; if (bus_a.outs_last !== el[i]) begin
        $display("FAIL wrap_last%0d: got %b want %b", i, bus_a.outs_last, el[i]); errors++; end
      checks++; if (bus_a.ctrl_ready !== 1'b1) begin
        $display("FAIL wrap_ready%0d: got %b want 1", i, bus_a.ctrl_ready); errors++; end
      if (i == 4) bus_a.ctrl_valid = 0;
    end
    @(posedge clk); #1;
    checks++; if (bus_a.outs_valid !== 1'b0) begin
      $display("FAIL wrap_drain: got %b want 0", bus_a.outs_valid); errors++; end
    checks++; if (bus_a.idx !== 2'd2) begin
      $display("FAIL wrap_idx: got %0d want 2", bus_a.idx); errors++; end
  endtask

  task automatic test_saturate_stream();
    logic [7:0] ew [5] = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h33};
    logic       el [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] ei [5] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    pulse_reset();
    bus_b.ctrl_valid = 1; bus_b.outs_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus_b.outs_valid !== 1'b1 || bus_b.outs !== ew[i]) begin
        $display("FAIL sat_word%0d: got v=%b %h want v=1 %h", i, bus_b.outs_valid, bus_b.outs,
                 ew[i]); errors++; end
      checks++; if (bus_b.outs_last !== el[i]) begin
        $display("FAIL sat_last%0d: got %b want %b", i, bus_b.outs_last, el[i]); errors++; end
      checks++; if (bus_b.idx !== ei[i]) begin
        $display("FAIL sat_idx%0d: got %0d want %0d", i, bus_b.idx, ei[i]); errors++; end
    end
    bus_b.ctrl_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    pulse_reset();
    bus_a.ctrl_valid = 1; bus_a.outs_ready = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_a.outs_valid !== 1'b1 || bus_a.outs !== 8'h11) begin
        $display("FAIL bp_hold%0d: got v=%b %h want v=1 11", i, bus_a.outs_valid, bus_a.outs);
        errors++; end
      checks++; if (bus_a.ctrl_ready !== 1'b0) begin
        $display("FAIL bp_ready%0d: got %b want 0", i, bus_a.ctrl_ready); errors++; end
      checks++; if (bus_a.idx !== 2'd1) begin
        $display("FAIL bp_idx%0d: got %0d want 1", i, bus_a.idx); errors++; end
      @(posedge clk); #1;
    end
    bus_a.outs_ready = 1;
    #1;
    checks++; if (bus_a.ctrl_ready !== 1'b1) begin
      $display("FAIL bp_ready_comb: got %b want 1", bus_a.ctrl_ready); errors++; end
    @(posedge clk); #1;
    checks++; if (bus_a.outs_valid !== 1'b1 || bus_a.outs !== 8'h22) begin
      $display("FAIL bp_next: got v=%b %h want v=1 22", bus_a.outs_valid, bus_a.outs); errors++; end
    bus_a.ctrl_valid = 0;
    @(posedge clk); #1;
    checks++; if (bus_a.outs_valid !== 1'b0) begin
      $display("FAIL bp_drain: got %b want 0", bus_a.outs_valid); errors++; end
  endtask

  task automatic test_restart();
    logic [7:0] ew [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
    pulse_reset();
    bus_a.ctrl_valid = 1; bus_a.outs_ready = 1;
    for (int i = 0; i < 4; i++) begin
      bus_a.seq_restart = (i == 1);
      @(posedge clk); #1;
      checks++; if (bus_a.outs_valid !== 1'b1 || bus_a.outs !== ew[i]) begin
        $display("FAIL rs_word%0d: got v=%b %h want v=1 %h", i, bus_a.outs_valid, bus_a.outs,
                 ew[i]); errors++; end
      if (i == 1) begin
        checks++; if (bus_a.idx !== 2'd0) begin
          $display("FAIL rs_idx: got %0d want 0", bus_a.idx); errors++; end
      end
    end
    // Restart while a word is held must leave the slot alone.
    bus_a.seq_restart = 0; bus_a.ctrl_valid = 0; bus_a.outs_ready = 0;
    @(posedge clk); #1;
    bus_a.seq_restart = 1;
    @(posedge clk); #1;
    bus_a.seq_restart = 0;
    checks++; if (bus_a.outs_valid !== 1'b1 || bus_a.outs !== 8'h22) begin
      $display("FAIL rs_held: got v=%b %h want v=1 22", bus_a.outs_valid, bus_a.outs); errors++; end
    checks++; if (bus_a.idx !== 2'd0) begin
      $display("FAIL rs_held_idx: got %0d want 0", bus_a.idx); errors++; end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    bus_a.ctrl_valid = 1; bus_a.outs_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_a.ctrl_valid = 0; bus_a.outs_ready = 0;
    checks++; if (bus_a.outs_valid !== 1'b1 || bus_a.outs !== 8'h22) begin
      $display("FAIL ar_pre: got v=%b %h want v=1 22", bus_a.outs_valid, bus_a.outs); errors++; end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (bus_a.outs_valid !== 1'b0 || bus_a.outs !== 8'h00) begin
      $display("FAIL ar_clear: got v=%b %h want v=0 00", bus_a.outs_valid, bus_a.outs); errors++; end
    checks++; if (bus_a.idx !== 2'd0 || bus_a.outs_last !== 1'b0) begin
      $display("FAIL ar_idx_last: got idx=%0d last=%b want 0 0", bus_a.idx, bus_a.outs_last);
      errors++; end
    checks++; if (bus_a.ctrl_ready !== 1'b1) begin
      $display("FAIL ar_ready: got %b want 1", bus_a.ctrl_ready); errors++; end
    rst = 1'b1;
    bus_a.ctrl_valid = 1; bus_a.outs_ready = 1;
    @(posedge clk); #1;
    bus_a.ctrl_valid = 0;
    checks++; if (bus_a.outs_valid !== 1'b1 || bus_a.outs !== 8'h11) begin
      $display("FAIL ar_first: got v=%b %h want v=1 11", bus_a.outs_valid, bus_a.outs); errors++; end
    @(posedge clk); #1;
  endtask

  task automatic test_depth1();
    logic mv;
    logic cv;
    logic rd;
    logic acc;
    int   tin;
    int   tout;
    pulse_reset();
    mv = 0; tin = 0; tout = 0;
    for (int i = 0; i < 40; i++) begin
      cv = (i < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
      rd = (i < 30) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_c.ctrl_valid = cv; bus_c.outs_ready = rd;
      #1;
      checks++; if (bus_c.outs_valid !== mv) begin
        $display("FAIL d1_valid%0d: got %b want %b", i, bus_c.outs_valid, mv); errors++; end
      checks++; if (bus_c.ctrl_ready !== (!mv || rd)) begin
        $display("FAIL d1_ready%0d: got %b want %b", i, bus_c.ctrl_ready, (!mv || rd)); errors++; end
      if (bus_c.outs_valid === 1'b1 && rd) begin
        tout++;
        checks++; if (bus_c.outs !== 8'hA5 || bus_c.outs_last !== 1'b1) begin
          $display("FAIL d1_word%0d: got %h last=%b want a5 last=1", i, bus_c.outs,
                   bus_c.outs_last); errors++; end
      end
      if (cv && bus_c.ctrl_ready === 1'b1) tin++;
      acc = cv && (!mv || rd);
      mv  = acc ? 1'b1 : ((mv && rd) ? 1'b0 : mv);
      @(posedge clk); #1;
    end
    checks++; if (tin !== tout) begin
      $display("FAIL d1_count: got in=%0d out=%0d want equal", tin, tout); errors++; end
    checks++; if (bus_c.idx !== 1'b0) begin
      $display("FAIL d1_idx: got %0d want 0", bus_c.idx); errors++; end
  endtask

  initial begin
    test_reset();
    test_wrap_stream();
    test_saturate_stream();
    test_backpressure();
    test_restart();
    test_async_reset();
    test_depth1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
